pulse_period_meter: RTL and testbench

- Inverse of the clock-enable prescaler: measures the clk-cycle spacing between rising edges of an incoming strobe (step pulse, clk_ena, optical-interrupter pulse).
- Reports the spacing in T_scale encoding: period in cycles minus 1. A strobe from a prescaler programmed with T_scale reads back as T_meas = T_scale.
- Used for feed-rate readback and loop-back self-test of the step generators.

---
 rtl/pulse_period_meter.sv | 108 ++++++++++
 tb/tb_pulse_period_meter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Strobe period meter: measures the clk-cycle spacing between rising edges of
// pulse_in and reports it as period-1, the same encoding a prescaler's T_scale uses.
module pulse_period_meter #(
    parameter int unsigned SYNC_STAGES = 0,
    parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        aclr,
    input  logic        sclr,
    input  logic        enable,
    input  logic        pulse_in,
    output logic [15:0] T_meas,
    output logic        valid,
    output logic        timeout,
    output logic        stopped
);
    typedef enum logic [1:0] {IDLE, MEASURE, STOPPED} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] t_meas_q;
    logic        valid_q;
    logic        timeout_q;
    logic        stopped_q;
    logic        pulse_dly_q;
    logic        pulse_s;
    logic        edge_w;
    logic        soft_clr_w;
    logic [15:0] cnt_d;

    // Synchroniser is cleared only by aclr so an input held high through a
    // soft clear is still seen as a fresh edge once enabled again.
    generate
        if (SYNC_STAGES == 2) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) begin
                    sync_q <= 2'b00;
                end else begin
                    sync_q <= {sync_q[0], pulse_in};
                end
            end
            assign pulse_s = sync_q[1];
        end else begin : g_nosync
            assign pulse_s = pulse_in;
        end
    endgenerate

    assign edge_w     = pulse_s && !pulse_dly_q;
    assign soft_clr_w = sclr || !enable;
    assign cnt_d      = cnt_q + 16'd1;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            t_meas_q    <= 16'd0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stopped_q   <= 1'b1;
            pulse_dly_q <= 1'b0;
        end else if (soft_clr_w) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            t_meas_q    <= 16'd0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            stopped_q   <= 1'b1;
            pulse_dly_q <= 1'b0;
        end else begin
            pulse_dly_q <= pulse_s;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE, STOPPED: begin
                    // No reference yet: the first edge only starts the count.
                    if (edge_w) begin
                        cnt_q     <= 16'd0;
                        state_q   <= MEASURE;
                        stopped_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (edge_w) begin
                        t_meas_q <= cnt_q;
                        valid_q  <= 1'b1;
                        cnt_q    <= 16'd0;
                    end else if (cnt_q == TIMEOUT) begin
                        timeout_q <= 1'b1;
                        state_q   <= STOPPED;
                        stopped_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    stopped_q <= 1'b1;
                end
            endcase
        end
    end

    assign T_meas  = t_meas_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign stopped = stopped_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: three instances (TIMEOUT=20, TIMEOUT=FFFF, 2-FF sync)
// share one stimulus and are checked against a gap-arithmetic reference model.
module tb_pulse_period_meter;
    logic clk = 1'b0;
    logic aclr = 1'b1;
    logic sclr = 1'b0;
    logic enable = 1'b1;
    logic pulse_in = 1'b0;

    logic [15:0] t_o [3];
    logic        v_o [3];
    logic        to_o [3];
    logic        st_o [3];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_en = 1'b0;
    int  vcount [3] = '{0, 0, 0};
    int  tcount [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    pulse_period_meter #(.SYNC_STAGES(0), .TIMEOUT(16'd20)) u_dut_a (
        .clk(clk), .aclr(aclr), .sclr(sclr), .enable(enable), .pulse_in(pulse_in),
        .T_meas(t_o[0]), .valid(v_o[0]), .timeout(to_o[0]), .stopped(st_o[0]));
    pulse_period_meter #(.SYNC_STAGES(0), .TIMEOUT(16'hFFFF)) u_dut_b (
        .clk(clk), .aclr(aclr), .sclr(sclr), .enable(enable), .pulse_in(pulse_in),
        .T_meas(t_o[1]), .valid(v_o[1]), .timeout(to_o[1]), .stopped(st_o[1]));
    pulse_period_meter #(.SYNC_STAGES(2), .TIMEOUT(16'd20)) u_dut_c (
        .clk(clk), .aclr(aclr), .sclr(sclr), .enable(enable), .pulse_in(pulse_in),
        .T_meas(t_o[2]), .valid(v_o[2]), .timeout(to_o[2]), .stopped(st_o[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers the cycle of the last reference edge and works
    // out results from cycle differences.
    longint      cyc = 0;
    bit [1:0]    m_sh [3] = '{2'b00, 2'b00, 2'b00};
    bit          m_prev [3] = '{1'b0, 1'b0, 1'b0};
    bit          m_ref_ok [3] = '{1'b0, 1'b0, 1'b0};
    longint      m_ref [3] = '{0, 0, 0};
    logic [15:0] m_T [3] = '{16'd0, 16'd0, 16'd0};
    bit          m_v [3] = '{1'b0, 1'b0, 1'b0};
    bit          m_to [3] = '{1'b0, 1'b0, 1'b0};

    function automatic int sync_of(input int k);
        return (k == 2) ? 2 : 0;
    endfunction
    function automatic longint tmo_of(input int k);
        return (k == 1) ? 64'd65535 : 64'd20;
    endfunction

    always @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int k = 0; k < 3; k++) begin
                m_sh[k] = 2'b00; m_prev[k] = 1'b0; m_ref_ok[k] = 1'b0;
                m_T[k] = 16'd0; m_v[k] = 1'b0; m_to[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit s;
                s = (sync_of(k) == 2) ? m_sh[k][1] : pulse_in;
                m_sh[k] = {m_sh[k][0], pulse_in};
                m_v[k] = 1'b0;
                m_to[k] = 1'b0;
                if (sclr || !enable) begin
                    m_prev[k] = 1'b0; m_ref_ok[k] = 1'b0; m_T[k] = 16'd0;
                end else begin
                    if (s && !m_prev[k]) begin
                        if (m_ref_ok[k]) begin
                            m_v[k] = 1'b1;
                            m_T[k] = 16'(cyc - m_ref[k] - 1);
                        end
                        m_ref_ok[k] = 1'b1;
                        m_ref[k] = cyc;
                    end else if (m_ref_ok[k] && (cyc - m_ref[k] - 1) == tmo_of(k)) begin
                        m_to[k] = 1'b1;
                        m_ref_ok[k] = 1'b0;
                    end
                    m_prev[k] = s;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("mdl%0d_valid", k), v_o[k], m_v[k]);
                chk($sformatf("mdl%0d_timeout", k), to_o[k], m_to[k]);
                chk($sformatf("mdl%0d_stopped", k), st_o[k], !m_ref_ok[k]);
                chk($sformatf("mdl%0d_T", k), t_o[k], m_T[k]);
                chk($sformatf("mdl%0d_excl", k), v_o[k] & to_o[k], 0);
                if (v_o[k] === 1'b1) vcount[k]++;
                if (to_o[k] === 1'b1) tcount[k]++;
            end
        end
    end

    task automatic drive(input logic p, input int n);
        pulse_in = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sync();
        pulse_in = 1'b0; sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
    endtask

    task automatic aclr_pulse();
        #2 aclr = 1'b1;
        #1 chk("aclr_async_T", t_o[0], 0);
        chk("aclr_async_stopped", st_o[0], 1);
        @(negedge clk);
        #2 aclr = 1'b0;
        @(negedge clk);
    endtask

    task automatic step_rand();
        int r;
        r = $urandom_range(0, 299);
        sclr = (r == 0);
        enable = !(r == 1 || r == 2);
        if (r == 3) begin
            #2 aclr = 1'b1;
            #4 aclr = 1'b0;
        end
        @(negedge clk);
        sclr = 1'b0;
        enable = 1'b1;
    endtask

    typedef struct {
        logic        p;
        logic        sc;
        logic        en;
        logic        ev;
        logic [15:0] et;
        logic        eto;
        logic        es;
    } vec_t;
    vec_t tbl [16];

    initial begin
        int k, tc0, vc0;
        bit seen;
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_T", t_o[i], 0);
            chk("rst_valid", v_o[i], 0);
            chk("rst_timeout", to_o[i], 0);
            chk("rst_stopped", st_o[i], 1);
        end
        aclr = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            pulse_in = tbl[i].p; sclr = tbl[i].sc; enable = tbl[i].en;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), v_o[0], tbl[i].ev);
            chk($sformatf("tbl%0d_T", i), t_o[0], tbl[i].et);
            chk($sformatf("tbl%0d_timeout", i), to_o[0], tbl[i].eto);
            chk($sformatf("tbl%0d_stopped", i), st_o[0], tbl[i].es);
        end
        sclr = 1'b0; enable = 1'b1;

        // Prescaler loop-back, T_scale = 4
        clear_sync();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1);
            chk("lb_valid", v_o[0], (i > 0));
            if (i > 0) chk("lb_T", t_o[0], 4);
            chk("lb_stopped", st_o[0], 0);
            drive(1'b0, 4);
        end

        // Period change 3 -> 1000 on the wide-timeout instance
        clear_sync();
        #1 vc0 = vcount[1];
        for (int i = 0; i < 14; i++) begin
            if (i > 0) drive(1'b0, (i < 10 ? 3 : 1000) - 1);
            drive(1'b1, 1);
            chk("pc_valid", v_o[1], (i > 0));
            chk("pc_T", t_o[1], (i == 0) ? 0 : (i < 10 ? 2 : 999));
        end
        #1 chk("pc_valid_count", vcount[1] - vc0, 13);

        // Timeout with TIMEOUT = 20
        clear_sync();
        drive(1'b1, 1); drive(1'b0, 4); drive(1'b1, 1);
        chk("to_T4", t_o[0], 4);
        pulse_in = 1'b0; k = 0; seen = 1'b0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (to_o[0] === 1'b1) seen = 1'b1;
        end
        chk("to_latency", k, 21);
        chk("to_stopped", st_o[0], 1);
        chk("to_T_held", t_o[0], 4);
        drive(1'b0, 3); drive(1'b1, 1);
        chk("to_restart_valid", v_o[0], 0);
        chk("to_restart_stopped", st_o[0], 0);
        drive(1'b0, 6); drive(1'b1, 1);
        chk("to_next_valid", v_o[0], 1);
        chk("to_next_T", t_o[0], 6);

        // Boundary: spacing 21 reports TIMEOUT, spacing 22 times out
        clear_sync();
        #1 tc0 = tcount[0];
        drive(1'b1, 1); drive(1'b0, 20); drive(1'b1, 1);
        chk("bnd21_valid", v_o[0], 1);
        chk("bnd21_T", t_o[0], 20);
        chk("bnd21_timeout", to_o[0], 0);
        #1 chk("bnd21_to_count", tcount[0] - tc0, 0);
        drive(1'b0, 21); drive(1'b1, 1);
        chk("bnd22_valid", v_o[0], 0);
        chk("bnd22_T_held", t_o[0], 20);
        #1 chk("bnd22_to_count", tcount[0] - tc0, 1);

        // Clear mid-measurement: sclr, aclr, enable low
        for (int mode = 0; mode < 3; mode++) begin
            clear_sync();
            drive(1'b1, 1); drive(1'b0, 7); drive(1'b1, 1);
            chk("clr_pre_T", t_o[0], 7);
            drive(1'b0, 2);
            case (mode)
                0: begin sclr = 1'b1; @(negedge clk); sclr = 1'b0; end
                1: aclr_pulse();
                default: begin enable = 1'b0; @(negedge clk); enable = 1'b1; end
            endcase
            chk($sformatf("clr%0d_T", mode), t_o[0], 0);
            chk($sformatf("clr%0d_valid", mode), v_o[0], 0);
            chk($sformatf("clr%0d_stopped", mode), st_o[0], 1);
            drive(1'b0, 2); drive(1'b1, 1);
            chk($sformatf("clr%0d_first_valid", mode), v_o[0], 0);
            drive(1'b0, 7); drive(1'b1, 1);
            chk($sformatf("clr%0d_second_valid", mode), v_o[0], 1);
            chk($sformatf("clr%0d_second_T", mode), t_o[0], 7);
        end

        // Sync path: input held high across aclr release, then spacing 6
        drive(1'b1, 2);
        aclr_pulse();
        chk("sync_a_ref", st_o[0], 0);
        chk("sync_c_wait1", st_o[2], 1);
        drive(1'b1, 1);
        chk("sync_c_wait2", st_o[2], 1);
        drive(1'b1, 1);
        chk("sync_c_ref", st_o[2], 0);
        drive(1'b0, 3);
        for (int per = 0; per < 3; per++) begin
            for (int j = 0; j < 6; j++) begin
                drive((j == 0), 1);
                chk("sync_a_valid", v_o[0], (j == 0));
                chk("sync_c_valid", v_o[2], (j == 2));
                if (j == 0) chk("sync_a_T", t_o[0], 5);
                if (j == 2) chk("sync_c_T", t_o[2], 5);
            end
        end

        // Randomised edges, gaps straddling the timeout, occasional clears
        for (int e = 0; e < 150; e++) begin
            int gap, hi;
            gap = $urandom_range(2, 26);
            hi = $urandom_range(1, gap - 1);
            pulse_in = 1'b1;
            repeat (hi) step_rand();
            pulse_in = 1'b0;
            repeat (gap - hi) step_rand();
        end

        drive(1'b0, 3);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
